ifft8_serial: RTL and testbench

- Time-multiplexed 8-point radix-2 DIT inverse FFT. It is the inverse-direction counterpart of the team's parallel 8-point FFT.
- Accepts one frequency bin per cycle in Q5.7, computes x[n] = (1/8)·Σ X[k]·e^(+j2πkn/8) with one shared butterfly, and streams time samples out in Q3.9.
- Frames are 8 samples. Both ends use valid/ready handshakes.

---
 rtl/fft_pkg.sv | 66 ++++++
 rtl/ifft_butterfly.sv | 93 +++++++++
 rtl/ifft8_serial.sv | 223 ++++++++++++++++++++++
 tb/tb_ifft8_serial.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the serial 8-point inverse FFT:
//   - Q-format word widths (input Q5.7, internal Q5.11, output Q3.9)
//   - inverse twiddle constant c = 0.70703 in Q1.10 and twiddle select codes
//   - FSM state encoding (LOAD / COMPUTE / UNLOAD)
//   - 3-bit bit reversal and the saturation helpers used by the datapath
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int XFORM_N  = 8;
  localparam int IN_W     = 12;  // Q5.7
  localparam int IN_INT   = 5;
  localparam int OUT_W    = 12;  // Q3.9
  localparam int OUT_INT  = 3;
  localparam int INT_W    = 16;  // Q5.11

  // Wide signed scratch width for sums and rounding before saturation
  localparam int WIDE_W   = 24;

  // Twiddle magnitude cos(pi/4) = sin(pi/4) in Q1.10
  localparam int                 TW_FRAC = 10;
  localparam logic signed [11:0] TW_C    = 12'sd724;

  // Inverse twiddles: W0 = 1, W1i = c+jc, W2i = +j, W3i = -c+jc
  typedef enum logic [1:0] {
    TW_W0 = 2'd0,
    TW_W1 = 2'd1,
    TW_W2 = 2'd2,
    TW_W3 = 2'd3
  } tw_sel_e;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Clamp a wide value to the 16-bit internal working range
  function automatic logic signed [15:0] sat_int(input logic signed [WIDE_W-1:0] v);
    if (v > 24'sd32767) begin
      return 16'sh7fff;
    end else if (v < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // Clamp a wide value to the 12-bit output range
  function automatic logic signed [11:0] sat_out(input logic signed [WIDE_W-1:0] v);
    if (v > 24'sd2047) begin
      return 12'sh7ff;
    end else if (v < -24'sd2048) begin
      return 12'sh800;
    end else begin
      return v[11:0];
    end
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// -----------------------------------------------------------------------------
// ifft_butterfly
// Combinational radix-2 DIT butterfly for the inverse transform.
//   p = sat((a + b*w + 1) >>> 1),  q = sat((a - b*w + 1) >>> 1)
// The halving at every stage gives the overall 1/8 scale over three stages.
// Ports:
//   a_re/a_im  in  16  upper input, Q5.11 signed
//   b_re/b_im  in  16  lower input, Q5.11 signed
//   tw_sel     in   2  twiddle select (TW_W0..TW_W3)
//   p_re/p_im  out 16  a + b*w, scaled and saturated
//   q_re/q_im  out 16  a - b*w, scaled and saturated
// -----------------------------------------------------------------------------
module ifft_butterfly
  import fft_pkg::*;
(
  input  logic signed [INT_W-1:0] a_re,
  input  logic signed [INT_W-1:0] a_im,
  input  logic signed [INT_W-1:0] b_re,
  input  logic signed [INT_W-1:0] b_im,
  input  tw_sel_e                 tw_sel,
  output logic signed [INT_W-1:0] p_re,
  output logic signed [INT_W-1:0] p_im,
  output logic signed [INT_W-1:0] q_re,
  output logic signed [INT_W-1:0] q_im
);

  // 16x12 products plus one bit of headroom for the sum of two of them
  localparam int PW = 29;

  logic signed [PW-1:0]     prod_r;
  logic signed [PW-1:0]     prod_i;
  logic signed [WIDE_W-1:0] a_re_w;
  logic signed [WIDE_W-1:0] a_im_w;
  logic signed [WIDE_W-1:0] b_re_w;
  logic signed [WIDE_W-1:0] b_im_w;
  logic signed [WIDE_W-1:0] bw_re;
  logic signed [WIDE_W-1:0] bw_im;

  // Round half-up back to Q5.11 after a Q1.10 multiply
  function automatic logic signed [WIDE_W-1:0] tw_round(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] r;
    r = (x + PW'(512)) >>> TW_FRAC;
    return r[WIDE_W-1:0];
  endfunction

  // Halve with round half-up, then clamp to the working range
  function automatic logic signed [INT_W-1:0] half_sat(input logic signed [WIDE_W-1:0] v);
    logic signed [WIDE_W-1:0] h;
    h = (v + 24'sd1) >>> 1;
    return sat_int(h);
  endfunction

  always_comb begin
    a_re_w = WIDE_W'(a_re);
    a_im_w = WIDE_W'(a_im);
    b_re_w = WIDE_W'(b_re);
    b_im_w = WIDE_W'(b_im);
    prod_r = PW'(b_re) * PW'(TW_C);
    prod_i = PW'(b_im) * PW'(TW_C);
    bw_re  = b_re_w;
    bw_im  = b_im_w;
    unique case (tw_sel)
      TW_W0: begin
        bw_re = b_re_w;
        bw_im = b_im_w;
      end
      // (br + j bi)(c + j c) = c(br - bi) + j c(br + bi)
      TW_W1: begin
        bw_re = tw_round(prod_r - prod_i);
        bw_im = tw_round(prod_r + prod_i);
      end
      // Multiply by +j: (br, bi) -> (-bi, br)
      TW_W2: begin
        bw_re = -b_im_w;
        bw_im = b_re_w;
      end
      // (br + j bi)(-c + j c) = -c(br + bi) + j c(br - bi)
      TW_W3: begin
        bw_re = tw_round(-prod_r - prod_i);
        bw_im = tw_round(prod_r - prod_i);
      end
      default: begin
        bw_re = b_re_w;
        bw_im = b_im_w;
      end
    endcase
    p_re = half_sat(a_re_w + bw_re);
    p_im = half_sat(a_im_w + bw_im);
    q_re = half_sat(a_re_w - bw_re);
    q_im = half_sat(a_im_w - bw_im);
  end

endmodule

// File: rtl/ifft8_serial.sv
// -----------------------------------------------------------------------------
// ifft8_serial
// Time-multiplexed 8-point radix-2 DIT inverse FFT with one shared butterfly.
// Bins arrive one per cycle (Q5.7) and are stored bit-reversed; 12 in-place
// butterflies follow; time samples leave in natural order (Q3.9).
// Ports:
//   clk        in   1  clock, posedge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  input bin valid
//   in_ready   out  1  high in LOAD
//   in_real    in  12  bin real, Q5.7
//   in_imag    in  12  bin imag, Q5.7
//   out_valid  out  1  time sample valid
//   out_ready  in   1  downstream accepts sample
//   out_real   out 12  sample real, Q3.9
//   out_imag   out 12  sample imag, Q3.9
//   out_last   out  1  marks sample n=7
//   busy       out  1  high in COMPUTE or UNLOAD
// -----------------------------------------------------------------------------
module ifft8_serial
  import fft_pkg::*;
#(
  parameter int N                 = XFORM_N,
  parameter int IN_WORD_WIDTH     = IN_W,
  parameter int IN_INTEGER_WIDTH  = IN_INT,
  parameter int OUT_WORD_WIDTH    = OUT_W,
  parameter int OUT_INTEGER_WIDTH = OUT_INT,
  parameter int INT_WORD_WIDTH    = INT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [IN_WORD_WIDTH-1:0]  in_real,
  input  logic signed [IN_WORD_WIDTH-1:0]  in_imag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [OUT_WORD_WIDTH-1:0] out_real,
  output logic signed [OUT_WORD_WIDTH-1:0] out_imag,
  output logic                             out_last,
  output logic                             busy
);

  localparam int AW        = $clog2(N);
  localparam int BFW       = 4;
  localparam int BF_LAST   = 3 * (N / 2) - 1;
  localparam int INT_FRAC  = INT_WORD_WIDTH - IN_INTEGER_WIDTH;
  localparam int IN_SHIFT  = INT_FRAC - (IN_WORD_WIDTH - IN_INTEGER_WIDTH);
  localparam int OUT_SHIFT = INT_FRAC - (OUT_WORD_WIDTH - OUT_INTEGER_WIDTH);
  localparam int OUT_RND   = 1 << (OUT_SHIFT - 1);

  state_e                            state_q, state_d;
  logic [AW-1:0]                     k_q, k_d;
  logic [AW-1:0]                     n_q, n_d;
  logic [BFW-1:0]                    bf_q, bf_d;
  logic signed [INT_WORD_WIDTH-1:0]  buf_re_q [N];
  logic signed [INT_WORD_WIDTH-1:0]  buf_im_q [N];
  logic signed [INT_WORD_WIDTH-1:0]  buf_re_d [N];
  logic signed [INT_WORD_WIDTH-1:0]  buf_im_d [N];
  logic                              out_valid_q, out_valid_d;
  logic                              out_last_q, out_last_d;
  logic signed [OUT_WORD_WIDTH-1:0]  out_real_q, out_real_d;
  logic signed [OUT_WORD_WIDTH-1:0]  out_imag_q, out_imag_d;

  logic [1:0]                        stage;
  logic [1:0]                        grp;
  logic [AW-1:0]                     a_addr;
  logic [AW-1:0]                     b_addr;
  logic [AW-1:0]                     wr_addr;
  logic [AW-1:0]                     n_nxt;
  tw_sel_e                           tw_sel;
  logic signed [INT_WORD_WIDTH-1:0]  p_re, p_im, q_re, q_im;

  // Q5.11 -> Q3.9 with round half-up and clamp
  function automatic logic signed [OUT_WORD_WIDTH-1:0] to_out(
    input logic signed [INT_WORD_WIDTH-1:0] v
  );
    logic signed [WIDE_W-1:0] r;
    r = (WIDE_W'(v) + WIDE_W'(OUT_RND)) >>> OUT_SHIFT;
    return sat_out(r);
  endfunction

  // Butterfly schedule: bf_q[3:2] is the stage (span 1,2,4), bf_q[1:0] the
  // butterfly within the stage.  The upper address has a zero in the span bit.
  always_comb begin
    stage  = bf_q[3:2];
    grp    = bf_q[1:0];
    a_addr = {grp, 1'b0};
    tw_sel = TW_W0;
    unique case (stage)
      2'd0: begin
        a_addr = {grp, 1'b0};
        tw_sel = TW_W0;
      end
      2'd1: begin
        a_addr = {grp[1], 1'b0, grp[0]};
        tw_sel = grp[0] ? TW_W2 : TW_W0;
      end
      default: begin
        a_addr = {1'b0, grp};
        tw_sel = tw_sel_e'(grp);
      end
    endcase
    b_addr = a_addr | (AW'(1) << stage);
  end

  ifft_butterfly u_bfly (
    .a_re   (buf_re_q[a_addr]),
    .a_im   (buf_im_q[a_addr]),
    .b_re   (buf_re_q[b_addr]),
    .b_im   (buf_im_q[b_addr]),
    .tw_sel (tw_sel),
    .p_re   (p_re),
    .p_im   (p_im),
    .q_re   (q_re),
    .q_im   (q_im)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    bf_d        = bf_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    wr_addr     = bitrev3(k_q);
    n_nxt       = n_q + AW'(1);

    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          buf_re_d[wr_addr] = INT_WORD_WIDTH'(in_real) <<< IN_SHIFT;
          buf_im_d[wr_addr] = INT_WORD_WIDTH'(in_imag) <<< IN_SHIFT;
          k_d = k_q + AW'(1);
          if (k_q == AW'(N - 1)) begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        buf_re_d[a_addr] = p_re;
        buf_im_d[a_addr] = p_im;
        buf_re_d[b_addr] = q_re;
        buf_im_d[b_addr] = q_im;
        bf_d = bf_q + BFW'(1);
        if (bf_q == BFW'(BF_LAST)) begin
          bf_d    = '0;
          n_d     = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        // n_q indexes the sample currently held on out_*; the first UNLOAD
        // cycle only fetches sample 0.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_real_d  = to_out(buf_re_q[n_q]);
          out_imag_d  = to_out(buf_im_q[n_q]);
          out_last_d  = (n_q == AW'(N - 1));
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            n_d         = '0;
            k_d         = '0;
            state_d     = LOAD;
          end else begin
            n_d        = n_nxt;
            out_real_d = to_out(buf_re_q[n_nxt]);
            out_imag_d = to_out(buf_im_q[n_nxt]);
            out_last_d = (n_nxt == AW'(N - 1));
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      k_q         <= '0;
      n_q         <= '0;
      bf_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      for (int i = 0; i < N; i++) begin
        buf_re_q[i] <= '0;
        buf_im_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      bf_q        <= bf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      for (int i = 0; i < N; i++) begin
        buf_re_q[i] <= buf_re_d[i];
        buf_im_q[i] <= buf_im_d[i];
      end
    end
  end

  // Outputs read as idle for the whole reset cycle, not just after the edge
  assign in_ready  = (state_q == LOAD) && !rst;
  assign busy      = (state_q != LOAD) && !rst;
  assign out_valid = out_valid_q && !rst;
  assign out_last  = out_last_q && !rst;
  assign out_real  = rst ? '0 : out_real_q;
  assign out_imag  = rst ? '0 : out_imag_q;

endmodule

// File: tb/tb_ifft8_serial.sv
module tb_ifft8_serial;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] in_real = '0;
  logic signed [11:0] in_imag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [11:0] out_real;
  logic signed [11:0] out_imag;
  logic               out_last;
  logic               busy;

  ifft8_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [11:0] fr_re [8];
  logic signed [11:0] fr_im [8];
  logic signed [11:0] ex_re [8];
  logic signed [11:0] ex_im [8];
  logic signed [11:0] got_re [8];
  logic signed [11:0] got_im [8];
  logic               got_last [8];

  int acc7;
  int first_cyc;
  bit load_timeout;
  bit cap_timeout;
  int hold_bad;
  int rdy_bad;
  logic after_ready;
  logic after_valid;

  // Drives one frame; all driving happens at negedges.
  task automatic load_frame(input bit gaps);
    int guard;
    load_timeout = 0;
    for (int k = 0; k < 8; k++) begin
      if (gaps && k[0]) begin
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      in_valid = 1'b1;
      in_real  = fr_re[k];
      in_imag  = fr_im[k];
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        load_timeout = 1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (k == 7) acc7 = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
  endtask

  // Records 8 output samples; optionally holds out_ready low 3 cycles at stall_n.
  task automatic capture_frame(input int stall_n);
    int guard;
    cap_timeout = 0;
    hold_bad = 0;
    rdy_bad = 0;
    for (int n = 0; n < 8; n++) begin
      got_re[n] = 'x;
      got_im[n] = 'x;
      got_last[n] = 'x;
    end
    for (int n = 0; n < 8; n++) begin
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!out_valid) begin
        cap_timeout = 1;
        return;
      end
      if (n == 0) first_cyc = cyc;
      got_re[n]   = out_real;
      got_im[n]   = out_imag;
      got_last[n] = out_last;
      if (n == stall_n) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (out_real !== got_re[n] || out_imag !== got_im[n] ||
              out_valid !== 1'b1 || out_last !== got_last[n]) hold_bad++;
          if (in_ready !== 1'b0) rdy_bad++;
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    after_ready = in_ready;
    after_valid = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++;
    if (out_real !== 12'sd0 || out_imag !== 12'sd0) begin
      n_fail++; $display("FAIL rst_out_data got (%0d,%0d) want (0,0)", out_real, out_imag);
    end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got %b want 0", out_last); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy got %b want 0", busy); end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < 8; k++) begin fr_re[k] = '0; fr_im[k] = '0; end
    fr_re[0] = 12'sd128;
    load_frame(0);
    capture_frame(-1);
    n_checks++;
    if (load_timeout || cap_timeout) begin
      n_fail++; $display("FAIL impulse_timeout got load=%0d cap=%0d want 0 0", load_timeout, cap_timeout);
    end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== 12'sd64 || got_im[n] !== 12'sd0) begin
        n_fail++; $display("FAIL impulse_x%0d got (%0d,%0d) want (64,0)", n, got_re[n], got_im[n]);
      end
      n_checks++;
      if (got_last[n] !== (n == 7)) begin
        n_fail++; $display("FAIL impulse_last%0d got %b want %b", n, got_last[n], (n == 7));
      end
    end
    n_checks++;
    if (after_ready !== 1'b1 || after_valid !== 1'b0) begin
      n_fail++; $display("FAIL impulse_return_load got rdy=%b vld=%b want rdy=1 vld=0", after_ready, after_valid);
    end
  endtask

  task automatic test_dc();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 12'sd128; fr_im[k] = '0; ex_re[k] = '0; ex_im[k] = '0;
    end
    ex_re[0] = 12'sd512;
    load_frame(0);
    capture_frame(-1);
    n_checks++;
    if (cap_timeout) begin n_fail++; $display("FAIL dc_timeout got 1 want 0"); end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== ex_re[n] || got_im[n] !== ex_im[n]) begin
        n_fail++; $display("FAIL dc_x%0d got (%0d,%0d) want (%0d,%0d)", n, got_re[n], got_im[n], ex_re[n], ex_im[n]);
      end
    end
  endtask

  task automatic set_tone();
    for (int k = 0; k < 8; k++) begin fr_re[k] = '0; fr_im[k] = '0; end
    fr_re[1] = 12'sd1024;
    ex_re = '{12'sd512, 12'sd362, 12'sd0, -12'sd362, -12'sd512, -12'sd362, 12'sd0, 12'sd362};
    ex_im = '{12'sd0, 12'sd362, 12'sd512, 12'sd362, 12'sd0, -12'sd362, -12'sd512, -12'sd362};
  endtask

  task automatic test_tone();
    set_tone();
    load_frame(0);
    capture_frame(-1);
    n_checks++;
    if (cap_timeout || (first_cyc - acc7) != 13) begin
      n_fail++; $display("FAIL tone_latency got %0d cycles (timeout=%0d) want 13", first_cyc - acc7, cap_timeout);
    end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== ex_re[n] || got_im[n] !== ex_im[n]) begin
        n_fail++; $display("FAIL tone_x%0d got (%0d,%0d) want (%0d,%0d)", n, got_re[n], got_im[n], ex_re[n], ex_im[n]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 12'sd2047; fr_im[k] = 12'sd2047; ex_re[k] = '0; ex_im[k] = '0;
    end
    ex_re[0] = 12'sd2047;
    ex_im[0] = 12'sd2047;
    load_frame(0);
    capture_frame(-1);
    n_checks++;
    if (cap_timeout) begin n_fail++; $display("FAIL sat_timeout got 1 want 0"); end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== ex_re[n] || got_im[n] !== ex_im[n]) begin
        n_fail++; $display("FAIL sat_x%0d got (%0d,%0d) want (%0d,%0d)", n, got_re[n], got_im[n], ex_re[n], ex_im[n]);
      end
    end
  endtask

  task automatic test_input_gaps();
    set_tone();
    load_frame(1);
    capture_frame(-1);
    n_checks++;
    if (load_timeout || cap_timeout) begin
      n_fail++; $display("FAIL gaps_timeout got load=%0d cap=%0d want 0 0", load_timeout, cap_timeout);
    end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== ex_re[n] || got_im[n] !== ex_im[n]) begin
        n_fail++; $display("FAIL gaps_x%0d got (%0d,%0d) want (%0d,%0d)", n, got_re[n], got_im[n], ex_re[n], ex_im[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_tone();
    load_frame(0);
    capture_frame(3);
    n_checks++;
    if (cap_timeout) begin n_fail++; $display("FAIL bp_timeout got 1 want 0"); end
    n_checks++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad); end
    n_checks++;
    if (rdy_bad != 0) begin n_fail++; $display("FAIL bp_in_ready got %0d high cycles want 0", rdy_bad); end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== ex_re[n] || got_im[n] !== ex_im[n] || got_last[n] !== (n == 7)) begin
        n_fail++; $display("FAIL bp_x%0d got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)",
                           n, got_re[n], got_im[n], got_last[n], ex_re[n], ex_im[n], (n == 7));
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    int spurious;
    for (int k = 0; k < 8; k++) begin fr_re[k] = '0; fr_im[k] = '0; end
    fr_re[0] = 12'sd128;
    load_frame(0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_compute got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_in_reset got vld=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin n_fail++; $display("FAIL midrst_no_output got %0d valid cycles want 0", spurious); end
    load_frame(0);
    capture_frame(-1);
    n_checks++;
    if (cap_timeout) begin n_fail++; $display("FAIL midrst_timeout got 1 want 0"); end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (got_re[n] !== 12'sd64 || got_im[n] !== 12'sd0) begin
        n_fail++; $display("FAIL midrst_x%0d got (%0d,%0d) want (64,0)", n, got_re[n], got_im[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_tone();
    test_saturation();
    test_input_gaps();
    test_backpressure();
    test_reset_mid_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
